// File: rtl/fsm_stim_sequencer_if.sv
// ---------------------------------------------------------------------------
// fsm_stim_sequencer_if
// Host-side bundle of the stimulus sequencer: run request, pattern and length
// going in, status and captured results coming back.
//   start     : request to run (host -> sequencer)
//   pattern   : control bits, bit 0 driven first (host -> sequencer)
//   length    : number of bits to drive (host -> sequencer)
//   busy      : sequencer not idle (sequencer -> host)
//   done      : one-cycle end-of-run pulse (sequencer -> host)
//   out_trace : captured FSM output samples (sequencer -> host)
//   hit_count : number of 1s captured (sequencer -> host)
// Optional (macro FSM_STIM_ABORT_EN): abort (host -> sequencer) and
// aborted (sequencer -> host).
// ---------------------------------------------------------------------------
interface fsm_stim_sequencer_if #(
    parameter int PAT_W = 16
) ();
    localparam int CNT_W = $clog2(PAT_W + 1);

    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] length;
    logic             busy;
    logic             done;
    logic [PAT_W-1:0] out_trace;
    logic [CNT_W-1:0] hit_count;
`ifdef FSM_STIM_ABORT_EN
    logic             abort;
    logic             aborted;

    modport master (
        output start, pattern, length, abort,
        input  busy, done, out_trace, hit_count, aborted
    );
    modport slave (
        input  start, pattern, length, abort,
        output busy, done, out_trace, hit_count, aborted
    );
`else
    modport master (
        output start, pattern, length,
        input  busy, done, out_trace, hit_count
    );
    modport slave (
        input  start, pattern, length,
        output busy, done, out_trace, hit_count
    );
`endif
endinterface

// File: rtl/fsm_stim_sequencer.sv
// ---------------------------------------------------------------------------
// fsm_stim_sequencer
// Drives a 2-bit Mealy control FSM under test: holds it in reset for RST_CYC
// cycles, streams a programmed pattern LSB-first onto its control input, and
// captures its serial output (RESP_LAT cycles behind each control bit) into a
// trace register while counting output pulses.
// Ports:
//   clk       : system clock, all logic on posedge
//   reset     : synchronous, active-high reset
//   host      : fsm_stim_sequencer_if.slave (start/pattern/length in,
//               busy/done/out_trace/hit_count out)
//   dut_reset : reset to the FSM under test (reset OR state==RST)
//   ctrl_out  : registered serial control bit to the FSM
//   dut_out   : FSM output
// Optional feature, macro FSM_STIM_ABORT_EN: host.abort ends a run early
// through DONE with host.aborted flagged; partial results are kept.
// ---------------------------------------------------------------------------
module fsm_stim_sequencer #(
    parameter int PAT_W    = 16,
    parameter int RST_CYC  = 2,
    parameter int RESP_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    fsm_stim_sequencer_if.slave   host,
    output logic                  dut_reset,
    output logic                  ctrl_out,
    input  logic                  dut_out
);
    localparam int CNT_W   = $clog2(PAT_W + 1);
    localparam int MAX_A   = (RST_CYC > PAT_W) ? RST_CYC : PAT_W;
    localparam int TMR_MAX = (RESP_LAT > MAX_A) ? RESP_LAT : MAX_A;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RST   = 3'd1,
        DRIVE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_r, state_next_s;
    logic [TMR_W-1:0]   tmr_r, tmr_next_s;
    logic [PAT_W-1:0]   pat_sh_r;
    logic [CNT_W-1:0]   len_r, len_eff_s;
    logic [CNT_W-1:0]   samp_idx_r;
    logic [1:0]         lat_r;
    logic [PAT_W-1:0]   trace_r;
    logic [CNT_W-1:0]   hits_r;
    logic               ctrl_r, busy_r, done_r;
    logic               accept_s, running_s, samp_en_s, abort_hit_s;
`ifdef FSM_STIM_ABORT_EN
    logic               aborted_r;
`endif

    // Zero and over-range lengths fall back to the full pattern width.
    always_comb begin
        len_eff_s = CNT_W'(PAT_W);
        if ((host.length != {CNT_W{1'b0}}) && (host.length <= CNT_W'(PAT_W))) begin
            len_eff_s = host.length;
        end else begin
            len_eff_s = CNT_W'(PAT_W);
        end
    end

    // Run control strobes: accept, sampling window, early abort.
    always_comb begin
        accept_s    = (state_r == IDLE) && host.start;
        running_s   = (state_r == DRIVE) || (state_r == DRAIN);
        // lat_r counts the response latency from the first drive cycle; once
        // it saturates, one sample per cycle until len_r samples are taken.
        samp_en_s   = running_s && (lat_r == 2'(RESP_LAT)) && (samp_idx_r < len_r);
        abort_hit_s = 1'b0;
`ifdef FSM_STIM_ABORT_EN
        if (host.abort && ((state_r == RST) || running_s)) begin
            abort_hit_s = 1'b1;
        end else begin
            abort_hit_s = 1'b0;
        end
`endif
    end

    // Next-state logic; tmr_r times the RST, DRIVE and DRAIN phases.
    always_comb begin
        state_next_s = state_r;
        tmr_next_s   = tmr_r;
        case (state_r)
            IDLE: begin
                if (host.start) begin
                    state_next_s = RST;
                    tmr_next_s   = {TMR_W{1'b0}};
                end else begin
                    state_next_s = IDLE;
                end
            end
            RST: begin
                if (tmr_r == TMR_W'(RST_CYC - 1)) begin
                    state_next_s = DRIVE;
                    tmr_next_s   = {TMR_W{1'b0}};
                end else begin
                    tmr_next_s   = tmr_r + TMR_W'(1);
                end
            end
            DRIVE: begin
                if (tmr_r == (TMR_W'(len_r) - TMR_W'(1))) begin
                    state_next_s = (RESP_LAT > 0) ? DRAIN : DONE;
                    tmr_next_s   = {TMR_W{1'b0}};
                end else begin
                    tmr_next_s   = tmr_r + TMR_W'(1);
                end
            end
            DRAIN: begin
                if (tmr_r == TMR_W'(RESP_LAT - 1)) begin
                    state_next_s = DONE;
                    tmr_next_s   = {TMR_W{1'b0}};
                end else begin
                    tmr_next_s   = tmr_r + TMR_W'(1);
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
                tmr_next_s   = {TMR_W{1'b0}};
            end
        endcase
        if (abort_hit_s) begin
            state_next_s = DONE;
            tmr_next_s   = {TMR_W{1'b0}};
        end else begin
            state_next_s = state_next_s;
        end
    end

    // State, registered outputs, pattern shifter and capture registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            tmr_r      <= {TMR_W{1'b0}};
            pat_sh_r   <= {PAT_W{1'b0}};
            len_r      <= {CNT_W{1'b0}};
            samp_idx_r <= {CNT_W{1'b0}};
            lat_r      <= 2'd0;
            trace_r    <= {PAT_W{1'b0}};
            hits_r     <= {CNT_W{1'b0}};
            ctrl_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
`ifdef FSM_STIM_ABORT_EN
            aborted_r  <= 1'b0;
`endif
        end else begin
            state_r <= state_next_s;
            tmr_r   <= tmr_next_s;
            busy_r  <= (state_next_s != IDLE);
            done_r  <= (state_next_s == DONE);
            // ctrl_out is registered, so the bit for the coming drive cycle
            // is taken from the shifter one edge early.
            ctrl_r  <= (state_next_s == DRIVE) ? pat_sh_r[0] : 1'b0;
            if (accept_s) begin
                pat_sh_r   <= host.pattern;
                len_r      <= len_eff_s;
                samp_idx_r <= {CNT_W{1'b0}};
                lat_r      <= 2'd0;
                trace_r    <= {PAT_W{1'b0}};
                hits_r     <= {CNT_W{1'b0}};
`ifdef FSM_STIM_ABORT_EN
                aborted_r  <= 1'b0;
`endif
            end else begin
                if (state_next_s == DRIVE) begin
                    pat_sh_r <= pat_sh_r >> 1;
                end
                if (samp_en_s) begin
                    // Trace is cleared at accept, so OR-ing in each bit once
                    // is equivalent to an indexed write.
                    trace_r    <= trace_r | (PAT_W'(dut_out) << samp_idx_r);
                    hits_r     <= hits_r + CNT_W'(dut_out);
                    samp_idx_r <= samp_idx_r + CNT_W'(1);
                end else if (running_s && (lat_r != 2'(RESP_LAT))) begin
                    lat_r <= lat_r + 2'd1;
                end
`ifdef FSM_STIM_ABORT_EN
                if (abort_hit_s) begin
                    aborted_r <= 1'b1;
                end
`endif
            end
        end
    end

    // The FSM under test is reset together with this block.
    assign dut_reset      = reset | (state_r == RST);
    assign ctrl_out       = ctrl_r;
    assign host.busy      = busy_r;
    assign host.done      = done_r;
    assign host.out_trace = trace_r;
    assign host.hit_count = hits_r;
`ifdef FSM_STIM_ABORT_EN
    assign host.aborted   = aborted_r;
`endif
endmodule
